// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared constants, state encodings and types for the
//                pipeline stall/bubble controller.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    // Number of cycles a multiply/divide occupies the EXE stage.
    localparam int MULDIV_CYCLES = 4;

    // Counter width and the value loaded when a mul/div enters EXE.
    localparam int         MD_CNT_W    = 2;
    localparam logic [1:0] MD_CNT_LOAD = 2'(MULDIV_CYCLES - 1);

    // Polarity constants used throughout the pipeline.
    localparam logic RST_ENABLED   = 1'b1;
    localparam logic STOP          = 1'b1;
    localparam logic WRITE_ENABLED = 1'b1;

    // Register file address width.
    localparam int REG_ADDR_W = 5;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    // Returns 1 when a register number names a real (hazard-capable) register.
    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
        return (addr != '0);
    endfunction

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_cmp
//  Description : Combinational load-use hazard detector. Flags when the
//                instruction in ID reads the destination of a load that is
//                currently in EXE. Register 0 never produces a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_cmp
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] exe_waddr,
    input  logic                  exe_wena,
    input  logic                  exe_load,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    output logic                  load_use
);

    logic rs_match;
    logic rt_match;
    logic exe_producer;

    // Source matches and whether EXE holds a load that will write a real register.
    always_comb begin
        rs_match     = id_rs_used && (id_rs_addr == exe_waddr);
        rt_match     = id_rt_used && (id_rt_addr == exe_waddr);
        exe_producer = exe_load && exe_wena && is_real_reg(exe_waddr);
        load_use     = exe_producer && id_valid && (rs_match || rt_match);
    end

endmodule : pipe_hazard_cmp
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Pipeline stall controller. Inserts a one-cycle bubble on a
//                load-use hazard and freezes the front of the pipe while a
//                multi-cycle mul/div occupies EXE, bubbling EXE/MEM.
//                All outputs are combinational so the stall takes effect in
//                the same cycle the hazard is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rf_waddr,
    input  logic                  id_rf_wena,
    input  logic                  id_is_load,
    input  logic                  id_is_muldiv,
    input  logic                  id_valid,
    output logic                  pc_wena,
    output logic                  if_id_wena,
    output logic                  id_exe_wena,
    output logic                  id_exe_stall,
    output logic                  exe_mem_bubble,
    output logic                  md_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e             state_q,     state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q,    md_cnt_d;
    logic [REG_ADDR_W-1:0] exe_waddr_q, exe_waddr_d;
    logic                  exe_wena_q,  exe_wena_d;
    logic                  exe_load_q,  exe_load_d;

    logic load_use;
    logic md_start;
    logic md_draining;

    // ------------------------------------------------------------------
    // Hazard comparator against the shadow of the ID/EXE register
    // ------------------------------------------------------------------
    pipe_hazard_cmp u_hazard_cmp (
        .exe_waddr  (exe_waddr_q),
        .exe_wena   (exe_wena_q),
        .exe_load   (exe_load_q),
        .id_valid   (id_valid),
        .id_rs_addr (id_rs_addr),
        .id_rt_addr (id_rt_addr),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .load_use   (load_use)
    );

    // Stall outputs and FSM next-state: freeze while a mul/div counts down,
    // otherwise run normally or drop a single bubble on a load-use hazard.
    always_comb begin
        pc_wena        = WRITE_ENABLED;
        if_id_wena     = WRITE_ENABLED;
        id_exe_wena    = WRITE_ENABLED;
        id_exe_stall   = ~STOP;
        exe_mem_bubble = 1'b0;
        md_busy        = 1'b0;
        md_start       = 1'b0;
        md_draining    = 1'b0;
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;

        case (state_q)
            ST_MD_BUSY: begin
                md_busy = 1'b1;
                if (md_cnt_q != '0) begin
                    // Mul/div still computing: hold the front end, feed
                    // bubbles downstream.
                    pc_wena        = ~WRITE_ENABLED;
                    if_id_wena     = ~WRITE_ENABLED;
                    id_exe_wena    = ~WRITE_ENABLED;
                    exe_mem_bubble = 1'b1;
                    md_cnt_d       = md_cnt_q - 1'b1;
                end else begin
                    // Last EXE cycle: behave like IDLE so a following
                    // mul/div can issue without a gap.
                    md_draining = 1'b1;
                end
            end
            default: begin
                md_draining = 1'b1;
            end
        endcase

        if (md_draining) begin
            if (load_use) begin
                pc_wena      = ~WRITE_ENABLED;
                if_id_wena   = ~WRITE_ENABLED;
                id_exe_wena  = WRITE_ENABLED;
                id_exe_stall = STOP;
            end
            // A load-use hazard keeps the mul/div parked in ID.
            md_start = id_valid && id_is_muldiv && !load_use && id_exe_wena;
            if (md_start) begin
                state_d  = ST_MD_BUSY;
                md_cnt_d = MD_CNT_LOAD;
            end else begin
                state_d  = ST_IDLE;
                md_cnt_d = '0;
            end
        end
    end

    // Shadow of ID/EXE: cleared with a bubble, captured when ID/EXE advances.
    always_comb begin
        exe_waddr_d = exe_waddr_q;
        exe_wena_d  = exe_wena_q;
        exe_load_d  = exe_load_q;
        if (id_exe_stall == STOP) begin
            exe_waddr_d = '0;
            exe_wena_d  = 1'b0;
            exe_load_d  = 1'b0;
        end else if (id_exe_wena == WRITE_ENABLED) begin
            exe_waddr_d = id_rf_waddr;
            exe_wena_d  = id_rf_wena && id_valid;
            exe_load_d  = id_is_load && id_valid;
        end
    end

    // State, counter and shadow registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
            state_q     <= ST_IDLE;
            md_cnt_q    <= '0;
            exe_waddr_q <= '0;
            exe_wena_q  <= 1'b0;
            exe_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            exe_waddr_q <= exe_waddr_d;
            exe_wena_q  <= exe_wena_d;
            exe_load_q  <= exe_load_d;
        end
    end

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl. Directed vector
//                table plus hand-written multi-cycle sequences.
//                Expected output packing: {pc, if_id, id_exe, stall, bubble, md_busy}
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam logic [5:0] C_RUN = 6'b111000;  // normal flow
    localparam logic [5:0] C_LU  = 6'b001100;  // load-use bubble
    localparam logic [5:0] C_MD  = 6'b000011;  // mul/div counting
    localparam logic [5:0] C_MDL = 6'b111001;  // mul/div last cycle

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, id_rf_waddr;
    logic       id_rs_used, id_rt_used, id_rf_wena;
    logic       id_is_load, id_is_muldiv, id_valid;
    logic       pc_wena, if_id_wena, id_exe_wena, id_exe_stall, exe_mem_bubble, md_busy;
    logic [5:0] outs;

    assign outs = {pc_wena, if_id_wena, id_exe_wena, id_exe_stall, exe_mem_bubble, md_busy};

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_rf_waddr    (id_rf_waddr),
        .id_rf_wena     (id_rf_wena),
        .id_is_load     (id_is_load),
        .id_is_muldiv   (id_is_muldiv),
        .id_valid       (id_valid),
        .pc_wena        (pc_wena),
        .if_id_wena     (if_id_wena),
        .id_exe_wena    (id_exe_wena),
        .id_exe_stall   (id_exe_stall),
        .exe_mem_bubble (exe_mem_bubble),
        .md_busy        (md_busy)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] wa;
        logic       we;
        logic       ld;
        logic       md;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic valid, input int rs, input int rt,
                                input logic rsu, input logic rtu, input int wa,
                                input logic we, input logic ld, input logic md,
                                input logic [5:0] exp);
        vec_t v;
        v.valid = valid; v.rs = 5'(rs); v.rt = 5'(rt); v.rsu = rsu; v.rtu = rtu;
        v.wa = 5'(wa); v.we = we; v.ld = ld; v.md = md; v.exp = exp;
        return v;
    endfunction

    // Common instruction shapes
    function automatic vec_t lw(input int rd, input logic [5:0] exp);
        return mk(1, 1, 0, 1, 0, rd, 1, 1, 0, exp);
    endfunction
    function automatic vec_t alu(input int rs, input int rt, input int rd, input logic [5:0] exp);
        return mk(1, rs, rt, 1, 1, rd, 1, 0, 0, exp);
    endfunction
    function automatic vec_t mdop(input int rs, input int rt, input logic [5:0] exp);
        return mk(1, rs, rt, 1, 1, 0, 0, 0, 1, exp);
    endfunction
    function automatic vec_t nop(input logic [5:0] exp);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
    endfunction

    task automatic apply(input vec_t v);
        id_valid     = v.valid;
        id_rs_addr   = v.rs;
        id_rt_addr   = v.rt;
        id_rs_used   = v.rsu;
        id_rt_used   = v.rtu;
        id_rf_waddr  = v.wa;
        id_rf_wena   = v.we;
        id_is_load   = v.ld;
        id_is_muldiv = v.md;
    endtask

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Apply one vector just after a rising edge and sample at the falling edge.
    task automatic step(input vec_t v, input string nm);
        @(posedge clk); #1;
        apply(v);
        @(negedge clk);
        check(nm, outs, v.exp);
    endtask

    initial begin
        int busy_cnt;
        int bub_cnt;
        int run_cur;
        int run_max;
        vec_t seq[$];

        // ---------------- vector table ----------------
        tbl.push_back(nop(C_RUN));                 //  0 idle after reset
        tbl.push_back(lw(3, C_RUN));               //  1 lw $3
        tbl.push_back(alu(3, 5, 4, C_LU));         //  2 add $4,$3,$5 -> bubble
        tbl.push_back(alu(3, 5, 4, C_RUN));        //  3 add proceeds
        tbl.push_back(lw(0, C_RUN));               //  4 lw $0
        tbl.push_back(alu(0, 5, 4, C_RUN));        //  5 add $4,$0,$5 no hazard
        tbl.push_back(lw(7, C_RUN));               //  6 lw $7
        tbl.push_back(alu(1, 7, 8, C_LU));         //  7 rt match
        tbl.push_back(alu(1, 7, 8, C_RUN));        //  8
        tbl.push_back(lw(9, C_RUN));               //  9 lw $9
        tbl.push_back(mk(1, 2, 9, 1, 0, 8, 1, 0, 0, C_RUN)); // 10 rt=$9 unused
        tbl.push_back(lw(10, C_RUN));              // 11 lw $10
        tbl.push_back(mk(0, 10, 0, 1, 0, 0, 0, 0, 0, C_RUN)); // 12 invalid reader
        tbl.push_back(alu(10, 0, 11, C_RUN));      // 13 invalid slot wiped shadow
        tbl.push_back(mdop(1, 2, C_RUN));          // 14 mult issues
        tbl.push_back(alu(4, 5, 6, C_MD));         // 15
        tbl.push_back(alu(4, 5, 6, C_MD));         // 16
        tbl.push_back(alu(4, 5, 6, C_MD));         // 17
        tbl.push_back(alu(4, 5, 6, C_MDL));        // 18 last mult cycle
        tbl.push_back(nop(C_RUN));                 // 19 back in IDLE
        tbl.push_back(lw(2, C_RUN));               // 20 lw $2
        tbl.push_back(mdop(2, 3, C_LU));           // 21 mult reads $2: held
        tbl.push_back(mdop(2, 3, C_RUN));          // 22 mult issues now
        tbl.push_back(nop(C_MD));                  // 23
        tbl.push_back(nop(C_MD));                  // 24
        tbl.push_back(nop(C_MD));                  // 25
        tbl.push_back(nop(C_MDL));                 // 26
        tbl.push_back(nop(C_RUN));                 // 27

        // ---------------- reset ----------------
        rst = 1'b1;
        apply(nop(C_RUN));
        #2;
        check("reset_async", outs, C_RUN);
        @(negedge clk);
        check("reset_held", outs, C_RUN);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // ---------------- back-to-back mult then div ----------------
        // mult issues in cycle 0; div waits in ID and issues in the mult's
        // final cycle (4); div counts in 5..7 and finishes in 8.
        seq.push_back(mdop(1, 2, C_RUN));
        for (int i = 0; i < 3; i++) seq.push_back(mdop(3, 4, C_MD));
        seq.push_back(mdop(3, 4, C_MDL));
        for (int i = 0; i < 3; i++) seq.push_back(alu(5, 6, 7, C_MD));
        seq.push_back(alu(5, 6, 7, C_MDL));
        seq.push_back(nop(C_RUN));
        busy_cnt = 0; bub_cnt = 0; run_cur = 0; run_max = 0;
        for (int i = 0; i < seq.size(); i++) begin
            step(seq[i], $sformatf("b2b%0d", i));
            if (md_busy) begin busy_cnt++; run_cur++; end else run_cur = 0;
            if (run_cur > run_max) run_max = run_cur;
            if (exe_mem_bubble) bub_cnt++;
        end
        check_int("b2b_busy_cycles", busy_cnt, 8);
        check_int("b2b_busy_run", run_max, 8);
        check_int("b2b_bubbles", bub_cnt, 6);

        // ---------------- reset during mul/div ----------------
        step(mdop(1, 2, C_RUN), "rstmd_issue");
        step(nop(C_MD), "rstmd_cnt3");
        step(nop(C_MD), "rstmd_cnt2");
        #1 rst = 1'b1;
        #1 check("rstmd_same_cycle", outs, C_RUN);
        @(posedge clk); #1;
        check("rstmd_held", outs, C_RUN);
        @(negedge clk);
        rst = 1'b0;
        step(alu(4, 5, 6, C_RUN), "rstmd_after0");
        step(nop(C_RUN), "rstmd_after1");

        // ---------------- reset clears the load shadow ----------------
        step(lw(6, C_RUN), "rstsh_lw");
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        apply(nop(C_RUN));
        step(alu(6, 0, 7, C_RUN), "rstsh_reader");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
